// File: rtl/sync_fifo_flex_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_flex.
// The FIFO takes the slave side; the stage driving it takes the master side.
interface sync_fifo_flex_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             rd_en;
  logic             valid;
  logic [WIDTH-1:0] data_out;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  ready, valid, data_out, count, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output ready, valid, data_out, count, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO using all DEPTH entries, with optional first-word-fall-through,
// occupancy count, almost-full/empty thresholds, flush and overflow/underflow pulses.
module sync_fifo_flex #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AFULL_THR  = DEPTH - 2,
  parameter int AEMPTY_THR = 2
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_flex_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wptr;
  logic [CW-1:0]    rptr;
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;
  logic [CW-1:0]    occupancy;

  assign waddr = wptr[AW-1:0];
  assign raddr = rptr[AW-1:0];

  // The extra wrap bit distinguishes full from empty when the addresses coincide.
  assign empty     = (wptr == rptr);
  assign full      = (waddr == raddr) && (wptr[AW] != rptr[AW]);
  assign occupancy = wptr - rptr;

  assign wr_acc = bus.wr_en && !full && !bus.flush;
  assign rd_acc = bus.rd_en && !empty && !bus.flush;

  assign bus.ready        = !full;
  assign bus.valid        = !empty;
  assign bus.count        = occupancy;
  assign bus.almost_full  = (occupancy >= AFULL_C);
  assign bus.almost_empty = (occupancy <= AEMPTY_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else if (bus.flush) begin
      wptr          <= '0;
      rptr          <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + CW'(1);
      if (rd_acc) rptr <= rptr + CW'(1);
      bus.overflow  <= bus.wr_en && full;
      bus.underflow <= bus.rd_en && empty;
    end
  end

  // Storage has no reset so it can map onto plain register/RAM resources.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[waddr] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = mem[raddr];
    end else begin : g_std
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         bus.data_out <= '0;
        else if (rd_acc) bus.data_out <= mem[raddr];
      end
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench: a standard-mode FIFO (A) and an FWFT FIFO with thresholds 14/2 (B).
module tb_sync_fifo_flex;
  logic clk;
  logic rst;
  int   check_count;
  int   pass_count;

  sync_fifo_flex_if #(.WIDTH(8), .DEPTH(16)) a_if ();
  sync_fifo_flex_if #(.WIDTH(8), .DEPTH(16)) b_if ();

  sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AFULL_THR(14), .AEMPTY_THR(2))
    dut_a (.clk(clk), .rst(rst), .bus(a_if));

  sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AFULL_THR(14), .AEMPTY_THR(2))
    dut_b (.clk(clk), .rst(rst), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      pass_count++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] din);
    a_if.wr_en   = wr;
    a_if.rd_en   = rd;
    a_if.data_in = din;
    tick();
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_word;
    int         wcnt;
    int         step;
    logic       do_wr;
    logic       do_rd;

    check_count = 0;
    pass_count  = 0;
    rst = 1'b1;
    a_if.flush = 0; a_if.wr_en = 0; a_if.rd_en = 0; a_if.data_in = 0;
    b_if.flush = 0; b_if.wr_en = 0; b_if.rd_en = 0; b_if.data_in = 0;
    #12;
    checkOutput("rst_count", a_if.count, 0);
    checkOutput("rst_valid", a_if.valid, 0);
    checkOutput("rst_ready", a_if.ready, 1);
    checkOutput("rst_dout", a_if.data_out, 0);
    checkOutput("rst_aempty", a_if.almost_empty, 1);
    checkOutput("rst_afull", a_if.almost_full, 0);
    rst = 1'b0;

    // FWFT: head word visible in the same cycle valid rises.
    b_if.wr_en = 1; b_if.data_in = 8'hA5;
    tick();
    checkOutput("fwft_valid", b_if.valid, 1);
    checkOutput("fwft_dout", b_if.data_out, 8'hA5);
    checkOutput("fwft_count1", b_if.count, 1);
    b_if.data_in = 8'h01;
    tick();
    checkOutput("fwft_ae_at2", b_if.almost_empty, 1);
    b_if.data_in = 8'h02;
    tick();
    checkOutput("fwft_ae_at3", b_if.almost_empty, 0);
    checkOutput("fwft_head_hold", b_if.data_out, 8'hA5);
    for (int v = 3; v <= 13; v++) begin
      b_if.data_in = 8'(v);
      tick();
      if (v == 12) checkOutput("fwft_af_at13", b_if.almost_full, 0);
    end
    b_if.wr_en = 0;
    checkOutput("fwft_count14", b_if.count, 14);
    checkOutput("fwft_af_at14", b_if.almost_full, 1);
    b_if.rd_en = 1;
    tick();
    b_if.rd_en = 0;
    checkOutput("fwft_next_word", b_if.data_out, 8'h01);
    checkOutput("fwft_count13", b_if.count, 13);
    checkOutput("fwft_af_drop", b_if.almost_full, 0);

    // Standard mode fill.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 8'(i));
      checkOutput("fill_count", a_if.count, i + 1);
    end
    a_if.wr_en = 0;
    checkOutput("full_ready", a_if.ready, 0);
    checkOutput("full_afull", a_if.almost_full, 1);

    applyStimulus(1, 0, 8'hEE);
    a_if.wr_en = 0;
    checkOutput("ovf_pulse", a_if.overflow, 1);
    checkOutput("ovf_count", a_if.count, 16);
    tick();
    checkOutput("ovf_one_cycle", a_if.overflow, 0);

    // Read and write at full: read wins, write refused.
    applyStimulus(1, 1, 8'h55);
    checkOutput("simfull_count", a_if.count, 15);
    checkOutput("simfull_dout", a_if.data_out, 8'h00);
    checkOutput("simfull_ready", a_if.ready, 1);
    checkOutput("simfull_ovf", a_if.overflow, 1);

    for (int i = 1; i < 16; i++) begin
      applyStimulus(0, 1, 8'h00);
      checkOutput("drain_dout", a_if.data_out, i);
    end
    a_if.rd_en = 0;
    checkOutput("drain_valid", a_if.valid, 0);
    checkOutput("drain_count", a_if.count, 0);
    tick();
    checkOutput("dout_hold", a_if.data_out, 8'h0F);

    applyStimulus(0, 1, 8'h00);
    a_if.rd_en = 0;
    checkOutput("udf_pulse", a_if.underflow, 1);
    checkOutput("udf_count", a_if.count, 0);
    tick();
    checkOutput("udf_one_cycle", a_if.underflow, 0);

    // Simultaneous access at count 5.
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 8'(8'h10 + i));
    applyStimulus(1, 1, 8'h15);
    checkOutput("sim5_count", a_if.count, 5);
    checkOutput("sim5_dout", a_if.data_out, 8'h10);
    q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

    // Interleaved traffic across pointer wraps, occupancy kept within 3..9.
    wcnt = 0;
    step = 0;
    while (wcnt < 40 && step < 200) begin
      do_wr = (q.size() < 9) && (step % 4 != 3);
      do_rd = (q.size() > 3) && (step % 3 != 0);
      applyStimulus(do_wr, do_rd, 8'(8'h40 + wcnt));
      if (do_wr) begin
        q.push_back(8'(8'h40 + wcnt));
        wcnt++;
      end
      if (do_rd) begin
        exp_word = q.pop_front();
        checkOutput("wrap_dout", a_if.data_out, exp_word);
      end
      checkOutput("wrap_count", a_if.count, q.size());
      step++;
    end
    checkOutput("wrap_all_written", wcnt, 40);
    while (q.size() > 0) begin
      applyStimulus(0, 1, 8'h00);
      exp_word = q.pop_front();
      checkOutput("wrap_drain", a_if.data_out, exp_word);
    end
    a_if.rd_en = 0;
    checkOutput("wrap_empty", a_if.valid, 0);

    // Flush beats a same-cycle write and leaves data_out alone.
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 8'(8'h80 + i));
    checkOutput("pre_flush_count", a_if.count, 4);
    a_if.flush = 1;
    applyStimulus(1, 0, 8'h99);
    a_if.flush = 0;
    a_if.wr_en = 0;
    checkOutput("flush_count", a_if.count, 0);
    checkOutput("flush_valid", a_if.valid, 0);
    checkOutput("flush_dout_kept", a_if.data_out, 8'h67);
    applyStimulus(1, 0, 8'h77);
    applyStimulus(0, 1, 8'h00);
    a_if.rd_en = 0;
    checkOutput("post_flush_dout", a_if.data_out, 8'h77);
    checkOutput("post_flush_count", a_if.count, 0);

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 7; i++) applyStimulus(1, 0, 8'(8'h30 + i));
    checkOutput("pre_rst_count", a_if.count, 7);
    a_if.data_in = 8'h37;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_count", a_if.count, 0);
    checkOutput("arst_valid", a_if.valid, 0);
    checkOutput("arst_ready", a_if.ready, 1);
    checkOutput("arst_dout", a_if.data_out, 0);
    checkOutput("arst_b_count", b_if.count, 0);
    a_if.wr_en = 0;
    #1;
    rst = 1'b0;
    tick();
    checkOutput("arst_hold_count", a_if.count, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
